// File: rtl/mem_responder_pkg.sv
// Shared CPU-side definitions for the memory responder slice.
//   CPU_BITS             : data/address width of the CPU bus
//   DEFAULT_DEPTH        : default number of 32-bit words stored
//   DEFAULT_WAIT_CYCLES  : default wait states between accept and response
//   state_t              : responder FSM state enumeration
package mem_responder_pkg;

  localparam int unsigned CPU_BITS            = 32;
  localparam int unsigned DEFAULT_DEPTH       = 2048;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: synchronous, byte-enabled,
// single read/write port, no reset (contents survive responder reset).
//   clk   : clock
//   en    : access strobe for this edge
//   we    : 1 = write bytes selected by be, 0 = read into rdata
//   be    : byte enables, bit i gates bits 8i+7..8i
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (updated only by reads)
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [AW-1:0]       addr,
  input  logic [CPU_BITS-1:0] wdata,
  output logic [CPU_BITS-1:0] rdata
);

  logic [CPU_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding-request memory responder with programmable wait states.
//   clk        : clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset (memory contents kept)
//   req_valid  : CPU presents a request
//   req_ready  : responder can accept (IDLE only)
//   req_wr     : 1 = store, 0 = load
//   req_addr   : word address, compared against DEPTH over all 32 bits
//   req_wdata  : store data
//   req_be     : store byte enables
//   rsp_valid  : response available (RESP only)
//   rsp_ready  : CPU accepts the response
//   rsp_rdata  : load data, 0 for stores and errors
//   rsp_err    : address out of range
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [CPU_BITS-1:0] req_addr,
  input  logic [CPU_BITS-1:0] req_wdata,
  input  logic [3:0]          req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CPU_BITS-1:0] rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [CPU_BITS-1:0] DEPTH_W   = CPU_BITS'(DEPTH);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic accept, fire;

  // captured request
  logic                wr_q;
  logic [CPU_BITS-1:0] addr_q;
  logic [CPU_BITS-1:0] wdata_q;
  logic [3:0]          be_q;

  // response flags; load_q marks that mem_array holds valid load data
  logic err_q;
  logic load_q;

  // access path: live inputs on a direct IDLE->RESP edge, captured otherwise
  logic                acc_wr;
  logic [CPU_BITS-1:0] acc_addr;
  logic [CPU_BITS-1:0] acc_wdata;
  logic [3:0]          acc_be;
  logic                acc_oob;
  logic [CPU_BITS-1:0] mem_rdata;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !reset) begin
          accept = 1'b1;
          if (WAIT_LOAD == '0) begin
            state_nx = RESP;
            fire     = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          fire     = !reset;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (state == IDLE) begin
      acc_wr    = req_wr;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_oob = (acc_addr >= DEPTH_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (fire) begin
        err_q  <= acc_oob;
        load_q <= !acc_wr && !acc_oob;
      end else if (state == RESP && rsp_ready) begin
        err_q  <= 1'b0;
        load_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .en    (fire && !acc_oob),
    .we    (acc_wr),
    .be    (acc_be),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // reset gates req_ready combinationally so it reads 0 while reset is held
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = load_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses
// WAIT_CYCLES=0; both use the default DEPTH of 2048.
module tb_mem_responder;

  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int errors = 0;
  int checks = 0;

  // reference memory per instance
  logic [31:0] ref_mem [2][DEPTH];
  int          exp_lat [2] = '{3, 1};

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Reference: apply a request to the model, return the expected response.
  task automatic model_apply(input int s, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] rdata, output logic err);
    rdata = 32'h0;
    err   = (addr >= 32'(DEPTH));
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[s][addr][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rdata = ref_mem[s][addr];
      end
    end
  endtask

  // Drives one transaction with rsp_ready high; reports latency in edges
  // counting the accept edge as the first one.
  task automatic txn(input int s, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata,
                     output logic err, output bit to);
    int n;
    to = 0; lat = 0; rdata = 32'h0; err = 1'b0;
    req_valid[s] = 1'b1; req_wr[s] = wr; req_addr[s] = addr;
    req_wdata[s] = wdata; req_be[s] = be; rsp_ready[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready[s]) begin to = 1; req_valid[s] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    req_wr[s]    = 1'($urandom);
    req_addr[s]  = $urandom;
    req_wdata[s] = $urandom;
    req_be[s]    = 4'($urandom);
    lat = 1;
    while (!rsp_valid[s] && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid[s]) begin to = 1; return; end
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_wr[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; req_be[s] = '0; rsp_ready[s] = 1'b1;
    end
    #1 reset = 1'b1;
    #2;
    for (int s = 0; s < 2; s++) begin
      checks += 4;
      if (req_ready[s] !== 1'b0) begin errors++; $display("FAIL reset_req_ready[%0d] got %b want 0", s, req_ready[s]); end
      if (rsp_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid[%0d] got %b want 0", s, rsp_valid[s]); end
      if (rsp_rdata[s] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata[%0d] got %h want 0", s, rsp_rdata[s]); end
      if (rsp_err[s] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err[%0d] got %b want 0", s, rsp_err[s]); end
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", req_ready[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd, erd; logic er, eer; bit to;
    model_apply(0, 1, 32'd5, 32'hDEADBEEF, 4'hF, erd, eer);
    txn(0, 1, 32'd5, 32'hDEADBEEF, 4'hF, lat, rd, er, to);
    checks += 3;
    if (to || lat != 3) begin errors++; $display("FAIL store_latency got %0d want 3 (timeout=%0d)", lat, to); end
    if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
    model_apply(0, 0, 32'd5, 32'h0, 4'h0, erd, eer);
    txn(0, 0, 32'd5, 32'h0, 4'h0, lat, rd, er, to);
    checks += 2;
    if (to || lat != 3) begin errors++; $display("FAIL load_latency got %0d want 3 (timeout=%0d)", lat, to); end
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] rd, erd; logic er, eer; bit to;
    model_apply(0, 1, 32'd7, 32'h11223344, 4'hF, erd, eer);
    txn(0, 1, 32'd7, 32'h11223344, 4'hF, lat, rd, er, to);
    model_apply(0, 1, 32'd7, 32'hAABBCCDD, 4'b0101, erd, eer);
    txn(0, 1, 32'd7, 32'hAABBCCDD, 4'b0101, lat, rd, er, to);
    model_apply(0, 1, 32'd7, 32'h55555555, 4'b0000, erd, eer);
    txn(0, 1, 32'd7, 32'h55555555, 4'b0000, lat, rd, er, to);
    txn(0, 0, 32'd7, 32'h0, 4'h0, lat, rd, er, to);
    checks++;
    if (to || rd !== 32'h11BB33DD) begin errors++; $display("FAIL partial_store got %h want 11bb33dd (timeout=%0d)", rd, to); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd, erd; logic er, eer; bit to;
    model_apply(0, 1, 32'd0, 32'h0BADF00D, 4'hF, erd, eer);
    txn(0, 1, 32'd0, 32'h0BADF00D, 4'hF, lat, rd, er, to);
    txn(0, 0, 32'd2048, 32'h0, 4'h0, lat, rd, er, to);
    checks += 3;
    if (to || lat != 3) begin errors++; $display("FAIL oob_load_latency got %0d want 3 (timeout=%0d)", lat, to); end
    if (er !== 1'b1) begin errors++; $display("FAIL oob_load_err got %b want 1", er); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oob_load_rdata got %h want 0", rd); end
    txn(0, 1, 32'd2048, 32'hFFFFFFFF, 4'hF, lat, rd, er, to);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL oob_store_err got %b want 1", er); end
    txn(0, 0, 32'd0, 32'h0, 4'h0, lat, rd, er, to);
    checks++;
    if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL oob_store_no_wrap got %h want 0badf00d", rd); end
    // high address bits must not alias onto valid words
    txn(0, 0, 32'h0001_0005, 32'h0, 4'h0, lat, rd, er, to);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_high_bits got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  task automatic test_backpressure;
    int n; logic [31:0] exp;
    exp = ref_mem[0][5];
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'd5; rsp_ready[0] = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!rsp_valid[0]) begin errors++; $display("FAIL bp_response_timeout got rsp_valid=0 want 1"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_hold cycle %0d got %b want 1", c, rsp_valid[0]); end
      if (rsp_rdata[0] !== exp) begin errors++; $display("FAIL bp_rdata_hold cycle %0d got %h want %h", c, rsp_rdata[0], exp); end
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle %0d got %b want 0", c, req_ready[0]); end
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", rsp_valid[0]); end
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", req_ready[0]); end
    if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL bp_release_rdata got %h want 0", rsp_rdata[0]); end
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [31:0] rd, erd; logic er, eer; bit to;
    model_apply(0, 1, 32'd9, 32'h0, 4'hF, erd, eer);
    txn(0, 1, 32'd9, 32'h0, 4'hF, lat, rd, er, to);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'd9;
    req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
    @(posedge clk); #1;  // accept edge
    req_valid[0] = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks += 4;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", req_ready[0]); end
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", rsp_valid[0]); end
    if (rsp_rdata[0] !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got %h want 0", rsp_rdata[0]); end
    if (rsp_err[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %b want 0", rsp_err[0]); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (rsp_valid[0]) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_no_response got %0d valid cycles want 0", seen); end
    txn(0, 0, 32'd9, 32'h0, 4'h0, lat, rd, er, to);
    checks++;
    if (to || rd !== 32'h0) begin errors++; $display("FAIL mid_reset_store_aborted got %h want 0 (timeout=%0d)", rd, to); end
  endtask

  task automatic test_zero_latency;
    int lat, cyc, k; int acc [4]; logic [31:0] rd, erd; logic er, eer; bit to, rdy;
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 32'(100 + 3 * i);
      model_apply(1, 1, a[i], $urandom, 4'hF, erd, eer);
      txn(1, 1, a[i], ref_mem[1][a[i]], 4'hF, lat, rd, er, to);
      checks++;
      if (to || lat != 1) begin errors++; $display("FAIL zl_store_latency %0d got %0d want 1", i, lat); end
    end
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = a[0];
    cyc = 0; k = 0;
    while (k < 4 && cyc < 40) begin
      rdy = req_ready[1];
      @(posedge clk); #1; cyc++;
      if (rdy) begin
        acc[k] = cyc;
        checks += 2;
        if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL zl_resp_latency %0d got rsp_valid=%b want 1", k, rsp_valid[1]); end
        if (rsp_rdata[1] !== ref_mem[1][a[k]]) begin errors++; $display("FAIL zl_rdata %0d got %h want %h", k, rsp_rdata[1], ref_mem[1][a[k]]); end
        if (k > 0) begin
          checks++;
          if (acc[k] - acc[k-1] != 2) begin errors++; $display("FAIL zl_accept_rate %0d got %0d want 2", k, acc[k] - acc[k-1]); end
        end
        k++;
        if (k < 4) req_addr[1] = a[k];
        else req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    checks++;
    if (k != 4) begin errors++; $display("FAIL zl_accept_count got %0d want 4", k); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, erd, addr, wd; logic er, eer; bit to, wr; logic [3:0] be;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) begin
        wd = $urandom;
        model_apply(s, 1, 32'(i), wd, 4'hF, erd, eer);
        txn(s, 1, 32'(i), wd, 4'hF, lat, rd, er, to);
      end
      for (int t = 0; t < 40; t++) begin
        wr = 1'($urandom);
        be = 4'($urandom);
        wd = $urandom;
        addr = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + $urandom_range(0, 32'h7FFF_0000)
                                           : 32'($urandom_range(0, 31));
        model_apply(s, wr, addr, wd, be, erd, eer);
        txn(s, wr, addr, wd, be, lat, rd, er, to);
        checks += 3;
        if (to || lat != exp_lat[s]) begin errors++; $display("FAIL rand_latency[%0d] t%0d got %0d want %0d", s, t, lat, exp_lat[s]); end
        if (er !== eer) begin errors++; $display("FAIL rand_err[%0d] t%0d addr %h got %b want %b", s, t, addr, er, eer); end
        if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d] t%0d addr %h got %h want %h", s, t, addr, rd, erd); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_partial_store;
    test_out_of_range;
    test_backpressure;
    test_reset_mid;
    test_zero_latency;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
